// File: rtl/dmem_pkg.sv
// dmem_pkg: address map, TX FSM states and status helpers for dmem_mmio
package dmem_pkg;
  localparam logic [31:0] MMIO_BASE        = 32'h8000_0000;
  localparam logic [31:0] UART_TXDATA_ADDR = MMIO_BASE;
  localparam logic [31:0] UART_STATUS_ADDR = MMIO_BASE + 32'h4;
  localparam logic [31:0] CYCLE_ADDR       = MMIO_BASE + 32'h8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic logic [3:0] sat4(input logic [31:0] v);
    return v > 32'd15 ? 4'hf : v[3:0];
  endfunction
endpackage

// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: byte FIFO feeding an 8N1 serial transmitter with registered output
module dmem_uart_tx
  import dmem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [7:0]                    data,
  output logic                          full,
  output logic                          empty,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          uart_tx
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CCW = $clog2(CLKS_PER_BIT);
  logic [7:0]     fifo [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [7:0]     sh;
  logic [CCW-1:0] clk_cnt;
  logic [2:0]     bit_cnt, nbit;
  tx_state_t      state, next;
  logic           tick, pop, push_ok, tx_d;
  assign full    = count == (PW+1)'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign busy    = state != IDLE;
  assign push_ok = push && !full;
  assign pop     = state == IDLE && !empty;
  assign tick    = clk_cnt == CCW'(CLKS_PER_BIT - 1);
  // FIFO storage needs no reset; pointers and count define validity
  always_ff @(posedge clk)
    if (push_ok) fifo[wr_ptr] <= data;
  // FIFO pointers and occupancy; full is judged on the pre-edge count
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_ok);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
    end
  // FSM state, bit timing counters, shift byte and the registered line
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= next;
      clk_cnt <= (state == IDLE || tick) ? '0 : clk_cnt + 1'b1;
      bit_cnt <= bit_cnt + 3'(state == DATA && tick);
      sh      <= pop ? fifo[rd_ptr] : sh;
      uart_tx <= tx_d;
    end
  // next-state: each non-idle state lasts CLKS_PER_BIT cycles, DATA eight times
  always_comb
    next = state == IDLE  ? (empty ? IDLE : START) :
           state == START ? (tick ? DATA : START) :
           state == DATA  ? ((tick && bit_cnt == 3'd7) ? STOP : DATA) :
                            (tick ? IDLE : STOP);
  // line level for the cycle after the edge, so uart_tx is a plain flop
  always_comb begin
    nbit = bit_cnt + 3'(state == DATA && tick);
    tx_d = next == START ? 1'b0 : next == DATA ? sh[nbit] : 1'b1;
  end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM plus UART TX and cycle counter MMIO; UART built only with DMEM_UART_EN
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        uart_tx
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   cyc, waddr, status;
  logic [AW-1:0] idx;
  logic          is_ram, wr;
  assign waddr  = Address & ~32'h3;
  assign is_ram = (waddr >> (AW + 2)) == 32'd0;
  assign idx    = Address[AW+1:2];
  assign wr     = MemWrite && !reset;
  // RAM keeps its contents across reset
  always_ff @(posedge clk)
    if (wr && is_ram) mem[idx] <= WriteData;
  // free-running cycle counter; a store to it clears it
  always_ff @(posedge clk or posedge reset)
    if (reset) cyc <= '0;
    else cyc <= (wr && waddr == CYCLE_ADDR) ? '0 : cyc + 32'd1;
`ifdef DMEM_UART_EN
  logic                        full, empty, busy;
  logic [$clog2(FIFO_DEPTH):0] count;
  dmem_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT), .FIFO_DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .reset(reset), .push(wr && waddr == UART_TXDATA_ADDR),
    .data(WriteData[7:0]), .full(full), .empty(empty), .busy(busy),
    .count(count), .uart_tx(uart_tx)
  );
  assign status = {24'd0, sat4(32'(count)), 2'b00, empty && !busy, full};
`else
  assign status  = 32'h0000_0002;
  assign uart_tx = 1'b1;
`endif
  // combinational load path; TXDATA and unmapped addresses read 0
  always_comb
    ReadData = is_ram                      ? mem[idx] :
               waddr == UART_STATUS_ADDR   ? status   :
               waddr == CYCLE_ADDR         ? cyc      : 32'd0;
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: randomized self-checking bench for dmem_mmio against a behavioural model
module tb_dmem_mmio;
  localparam int MW = 256, CPB = 4, FD = 8;
  localparam logic [31:0] TXA = 32'h8000_0000, STA = 32'h8000_0004, CYA = 32'h8000_0008;
  logic        clk = 0, reset = 1, MemWrite = 0, uart_tx;
  logic [31:0] Address = 0, WriteData = 0, ReadData;
  int          checks = 0, errors = 0;
  logic [31:0] model [MW];
  int          wl[$];

  dmem_mmio #(.MEM_WORDS(MW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .ReadData(ReadData), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1;
    @(negedge clk);
    MemWrite = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    #1 d = ReadData;
  endtask

  function automatic logic [31:0] unmapped();
    int sel = $urandom_range(0, 2);
    if (sel == 0) return 32'h8000_000C + 32'($urandom_range(0, 4000));
    if (sel == 1) return 32'(MW * 4) + 32'($urandom_range(0, 32'h7FFF_0000));
    return 32'hC000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF));
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    rd(STA, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_status got %h want %h", d, 32'h2); end
    step(3);
    rd(CYA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cycle got %h want 0", d); end
    reset = 0;
  endtask

  task automatic test_ram();
    logic [31:0] d;
    wr(32'h10, 32'hDEAD_BEEF); model[4] = 32'hDEAD_BEEF; wl.push_back(4);
    rd(32'h10, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rt got %h want deadbeef", d); end
    rd(32'h13, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rt_bytes got %h want deadbeef", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    wr(32'h0, 32'h1111_1111); model[0] = 32'h1111_1111; wl.push_back(0);
    wr(32'h4000_0000, 32'h1234_5678);
    rd(32'h4000_0000, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
    rd(32'h0, d);
    checks++; if (d !== 32'h1111_1111) begin errors++; $display("FAIL unmapped_alias got %h want 11111111", d); end
    rd(TXA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL txdata_read got %h want 0", d); end
  endtask

  task automatic test_random_ram();
    logic [31:0] d, a;
    for (int i = 0; i < 80; i++) begin
      int op = $urandom_range(0, 3);
      if (op == 0) begin
        int w = $urandom_range(0, MW - 1);
        d = $urandom;
        wr((32'(w) << 2) | 32'($urandom_range(0, 3)), d);
        model[w] = d; wl.push_back(w);
      end else if (op == 1) begin
        wr(unmapped(), $urandom);
      end else if (op == 2) begin
        int w = wl[$urandom_range(0, wl.size() - 1)];
        rd((32'(w) << 2) | 32'($urandom_range(0, 3)), d);
        checks++; if (d !== model[w]) begin errors++; $display("FAIL rand_ram w%0d got %h want %h", w, d, model[w]); end
        step();
      end else begin
        a = unmapped();
        rd(a, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rand_unmapped a%h got %h want 0", a, d); end
        step();
      end
    end
  endtask

  task automatic test_cycle();
    logic [31:0] d;
    wr(CYA, $urandom);
    rd(CYA, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL cycle_clear got %h want 0", d); end
    step();
    rd(CYA, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL cycle_plus1 got %h want 1", d); end
    step(5);
    rd(CYA, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL cycle_plus6 got %h want 6", d); end
    force dut.cyc = 32'hFFFF_FFFF;
    rd(CYA, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_forced got %h want ffffffff", d); end
    release dut.cyc;
    step();
    rd(CYA, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL cycle_wrap got %h want 0", d); end
  endtask

  task automatic test_reset_retain();
    logic [31:0] d, v;
    v = $urandom;
    wr(32'h20, v);
    reset = 1;
    Address = 32'h20; WriteData = ~v; MemWrite = 1;
    step(2);
    MemWrite = 0;
    reset = 0;
    rd(32'h20, d);
    checks++; if (d !== v) begin errors++; $display("FAIL reset_retain got %h want %h", d, v); end
  endtask

`ifdef DMEM_UART_EN
  task automatic recv(output logic [7:0] b, output bit ok);
    int t = 0;
    ok = 1; b = '0;
    while (t < 200 && uart_tx !== 1'b0) begin step(); t++; end
    if (uart_tx !== 1'b0) begin ok = 0; return; end
    step(CPB / 2);
    if (uart_tx !== 1'b0) ok = 0;
    for (int i = 0; i < 8; i++) begin step(CPB); b[i] = uart_tx; end
    step(CPB);
    if (uart_tx !== 1'b1) ok = 0;
  endtask

  task automatic test_frame();
    logic [31:0] d;
    logic [7:0]  b = 8'hA5;
    logic        e;
    wr(TXA, {24'd0, b});
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL frame_pre got %b want 1", uart_tx); end
    Address = STA;
    for (int k = 0; k < 10 * CPB; k++) begin
      step();
      e = k < CPB ? 1'b0 : k < 9 * CPB ? b[(k - CPB) / CPB] : 1'b1;
      checks++; if (uart_tx !== e) begin errors++; $display("FAIL frame_bit k%0d got %b want %b", k, uart_tx, e); end
      if (k == 10) begin
        rd(STA, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL frame_busy_status got %h want 0", d); end
      end
    end
    step();
    rd(STA, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL frame_done_status got %h want 2", d); end
  endtask

  task automatic test_overflow();
    logic [7:0]  b [10];
    logic [7:0]  got [$];
    logic [31:0] d;
    bit          extra;
    for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
    fork
      begin
        logic [7:0] r; bit ok;
        for (int i = 0; i < 9; i++) begin recv(r, ok); if (ok) got.push_back(r); end
        recv(r, ok);
        extra = ok;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          if (i == 9) begin
            rd(STA, d);
            checks++; if (d !== 32'h81) begin errors++; $display("FAIL ovf_full_status got %h want 81", d); end
          end
          wr(TXA, {24'd0, b[i]});
        end
        rd(STA, d);
        checks++; if (d !== 32'h81) begin errors++; $display("FAIL ovf_after_drop got %h want 81", d); end
      end
    join
    checks++; if (got.size() !== 9) begin errors++; $display("FAIL ovf_count got %0d want 9", got.size()); end
    for (int i = 0; i < got.size() && i < 9; i++) begin
      checks++; if (got[i] !== b[i]) begin errors++; $display("FAIL ovf_byte%0d got %h want %h", i, got[i], b[i]); end
    end
    checks++; if (extra) begin errors++; $display("FAIL ovf_dropped got frame want none"); end
    rd(STA, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ovf_end_status got %h want 2", d); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int t = 0, lows = 0;
    wr(TXA, {24'd0, 8'($urandom) & 8'hF7});
    wr(TXA, $urandom);
    wr(TXA, $urandom);
    while (t < 50 && uart_tx !== 1'b0) begin step(); t++; end
    step(4 * CPB + 1);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_bit3 got %b want 0", uart_tx); end
    #1 reset = 1;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx got %b want 1", uart_tx); end
    rd(STA, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL mid_reset_status got %h want 2", d); end
    step();
    reset = 0;
    for (int i = 0; i < 100; i++) begin step(); if (uart_tx !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL mid_residual got %0d low cycles want 0", lows); end
  endtask
`else
  task automatic test_uart_absent();
    logic [31:0] d;
    int lows = 0;
    wr(TXA, 32'h55);
    for (int i = 0; i < 60; i++) begin step(); if (uart_tx !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL absent_tx got %0d low cycles want 0", lows); end
    rd(STA, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL absent_status got %h want 2", d); end
    wr(STA, 32'hFFFF_FFFF);
    rd(STA, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL absent_status_wr got %h want 2", d); end
  endtask
`endif

  initial begin
    test_reset();
    step();
    test_ram();
    test_unmapped();
    test_random_ram();
    test_cycle();
`ifdef DMEM_UART_EN
    test_frame();
    test_overflow();
    test_reset_midframe();
`else
    test_uart_absent();
`endif
    test_reset_retain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
